prv32_ex_mem_stage: RTL and testbench

PRV32_EX_MEM_STAGE -- requirements
Module: prv32_ex_mem_stage

---
 rtl/prv32_ex_mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_prv32_ex_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prv32_ex_mem_stage.sv
// EX->MEM pipeline register for a 32-bit RISC-V core. It resolves branches and jumps and issues the fetch redirect.
// Latency: 1 cycle from EX capture to the out_* registers and to the redirect or misalign pulse.
// Backpressure: stall holds every out_* register and suppresses any repeat pulse. Flush kills the stage and overrides stall.
module prv32_ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] alu_r,
    input  logic        cf,
    input  logic        zf,
    input  logic        vf,
    input  logic        sf,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs2_data,
    input  logic        branch,
    input  logic        jal,
    input  logic        jalr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    output logic        out_valid,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [31:0] out_alu_r,
    output logic [31:0] out_rs2,
    output logic [31:0] out_link,
    output logic [2:0]  out_funct3,
    output logic [4:0]  out_rd,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        misalign
);

    // EMPTY: no live instruction. FULL: live and no pulse this cycle. FULL_PULSE: redirect or misalign is high now.
    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_FULL       = 2'd1,
        ST_FULL_PULSE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        fired_q, fired_d;
    logic        out_valid_q, out_valid_d;
    logic        out_reg_write_q, out_reg_write_d;
    logic        out_mem_read_q, out_mem_read_d;
    logic        out_mem_write_q, out_mem_write_d;
    logic [31:0] out_alu_r_q, out_alu_r_d;
    logic [31:0] out_rs2_q, out_rs2_d;
    logic [31:0] out_link_q, out_link_d;
    logic [2:0]  out_funct3_q, out_funct3_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        misalign_q, misalign_d;

    logic        br_cond;
    logic        take;
    logic [31:0] target;
    logic [31:0] link;
    logic        tgt_misaligned;

    // Branch resolution. cf=1 means no borrow, so BLTU is taken on !cf. The 010 and 011 encodings are never taken.
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = zf;
            3'b001:  br_cond = ~zf;
            3'b100:  br_cond = (sf != vf);
            3'b101:  br_cond = (sf == vf);
            3'b110:  br_cond = ~cf;
            3'b111:  br_cond = cf;
            default: br_cond = 1'b0;
        endcase
    end

    // Target and link addresses. Both wrap modulo 2^32. A JALR target has bit 0 cleared.
    always_comb begin
        take           = in_valid & (jal | jalr | (branch & br_cond));
        target         = jalr ? {alu_r[31:1], 1'b0} : (pc + imm);
        link           = pc + 32'd4;
        tgt_misaligned = target[1];
    end

    // Next-state computation. Flush wins over stall, and stall wins over capture. Reset is applied in the register block.
    always_comb begin
        state_d         = state_q;
        fired_d         = fired_q;
        out_valid_d     = out_valid_q;
        out_reg_write_d = out_reg_write_q;
        out_mem_read_d  = out_mem_read_q;
        out_mem_write_d = out_mem_write_q;
        out_alu_r_d     = out_alu_r_q;
        out_rs2_d       = out_rs2_q;
        out_link_d      = out_link_q;
        out_funct3_d    = out_funct3_q;
        out_rd_d        = out_rd_q;
        redirect_pc_d   = redirect_pc_q;
        redirect_d      = 1'b0;
        misalign_d      = 1'b0;

        if (flush) begin
            // Kill the instruction. Data registers and redirect_pc keep their last values.
            state_d         = ST_EMPTY;
            fired_d         = 1'b0;
            out_valid_d     = 1'b0;
            out_reg_write_d = 1'b0;
            out_mem_read_d  = 1'b0;
            out_mem_write_d = 1'b0;
        end else if (stall) begin
            // Hold the instruction. Remember that its pulse was already sent so it is never repeated.
            fired_d = fired_q | redirect_q | misalign_q;
            if (state_q == ST_FULL_PULSE) begin
                state_d = ST_FULL;
            end
        end else begin
            out_valid_d     = in_valid;
            out_reg_write_d = in_valid & reg_write;
            out_mem_read_d  = in_valid & mem_read;
            out_mem_write_d = in_valid & mem_write;
            out_alu_r_d     = alu_r;
            out_rs2_d       = rs2_data;
            out_link_d      = link;
            out_funct3_d    = funct3;
            out_rd_d        = rd;
            fired_d         = 1'b0;
            state_d         = in_valid ? ST_FULL : ST_EMPTY;
            if (take) begin
                // A misaligned target still records the address so the trap handler can see it.
                redirect_pc_d = target;
                state_d       = ST_FULL_PULSE;
                if (tgt_misaligned) begin
                    misalign_d      = 1'b1;
                    out_reg_write_d = 1'b0;
                    out_mem_read_d  = 1'b0;
                    out_mem_write_d = 1'b0;
                end else begin
                    redirect_d = 1'b1;
                end
            end
        end
    end

    // Stage registers with a synchronous active-high reset that clears every output and the fired flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_EMPTY;
            fired_q         <= 1'b0;
            out_valid_q     <= 1'b0;
            out_reg_write_q <= 1'b0;
            out_mem_read_q  <= 1'b0;
            out_mem_write_q <= 1'b0;
            out_alu_r_q     <= 32'd0;
            out_rs2_q       <= 32'd0;
            out_link_q      <= 32'd0;
            out_funct3_q    <= 3'd0;
            out_rd_q        <= 5'd0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= 32'd0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fired_q         <= fired_d;
            out_valid_q     <= out_valid_d;
            out_reg_write_q <= out_reg_write_d;
            out_mem_read_q  <= out_mem_read_d;
            out_mem_write_q <= out_mem_write_d;
            out_alu_r_q     <= out_alu_r_d;
            out_rs2_q       <= out_rs2_d;
            out_link_q      <= out_link_d;
            out_funct3_q    <= out_funct3_d;
            out_rd_q        <= out_rd_d;
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            misalign_q      <= misalign_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_reg_write = out_reg_write_q;
    assign out_mem_read  = out_mem_read_q;
    assign out_mem_write = out_mem_write_q;
    assign out_alu_r     = out_alu_r_q;
    assign out_rs2       = out_rs2_q;
    assign out_link      = out_link_q;
    assign out_funct3    = out_funct3_q;
    assign out_rd        = out_rd_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign misalign      = misalign_q;

endmodule

// File: tb/tb_prv32_ex_mem_stage.sv
// Directed testbench for prv32_ex_mem_stage. Each vector's expected outputs are worked out by hand.
// Latency: outputs are sampled 1 ns after the capturing rising edge.
// Backpressure: stall and flush are driven directly by the directed vectors.
module tb_prv32_ex_mem_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] alu_r;
    logic        cf, zf, vf, sf;
    logic [31:0] pc, imm, rs2_data;
    logic        branch, jal, jalr, mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic [31:0] out_alu_r, out_rs2, out_link;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;

    int n_checks;
    int n_errors;

    prv32_ex_mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .alu_r         (alu_r),
        .cf            (cf),
        .zf            (zf),
        .vf            (vf),
        .sf            (sf),
        .pc            (pc),
        .imm           (imm),
        .rs2_data      (rs2_data),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .funct3        (funct3),
        .rd            (rd),
        .out_valid     (out_valid),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_alu_r     (out_alu_r),
        .out_rs2       (out_rs2),
        .out_link      (out_link),
        .out_funct3    (out_funct3),
        .out_rd        (out_rd),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .misalign      (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count the comparison and report it if the observed value differs from the expected one.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive every instruction input to zero, leaving rst, stall and flush unchanged.
    task automatic clr();
        in_valid = 0; alu_r = 0; cf = 0; zf = 0; vf = 0; sf = 0;
        pc = 0; imm = 0; rs2_data = 0; branch = 0; jal = 0; jalr = 0;
        mem_read = 0; mem_write = 0; reg_write = 0; funct3 = 0; rd = 0;
    endtask

    // Load a conditional branch with the given funct3 and flags, at pc 0x400 with imm 0x10.
    task automatic br(input logic [2:0] f3, input logic c, input logic z, input logic v, input logic s);
        clr();
        in_valid = 1; branch = 1; funct3 = f3; cf = c; zf = z; vf = v; sf = s;
        pc = 32'h400; imm = 32'h10;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        stall = 0; flush = 0;
        clr();

        // Reset while a taken JAL is present at the inputs. All outputs must be zero and no redirect may fire.
        rst = 1; in_valid = 1; jal = 1; pc = 32'h100; imm = 32'h20; alu_r = 32'h1234;
        rs2_data = 32'h55; rd = 5'd3; reg_write = 1; funct3 = 3'b010;
        step();
        step();
        check("rst_valid",    {31'd0, out_valid}, 0);
        check("rst_redirect", {31'd0, redirect}, 0);
        check("rst_misalign", {31'd0, misalign}, 0);
        check("rst_rpc",      redirect_pc, 0);
        check("rst_alu",      out_alu_r, 0);
        check("rst_rs2",      out_rs2, 0);
        check("rst_link",     out_link, 0);
        check("rst_rd",       {27'd0, out_rd}, 0);
        check("rst_f3",       {29'd0, out_funct3}, 0);
        check("rst_rw",       {31'd0, out_reg_write}, 0);
        rst = 0;
        clr();
        step();

        // BEQ taken: the target is 0x100 + 0x20 = 0x120 and the link is 0x104.
        br(3'b000, 0, 1, 0, 0); pc = 32'h100; imm = 32'h20;
        step();
        check("beq_redirect", {31'd0, redirect}, 1);
        check("beq_rpc",      redirect_pc, 32'h120);
        check("beq_valid",    {31'd0, out_valid}, 1);
        check("beq_link",     out_link, 32'h104);
        clr();
        step();
        check("beq_pulse_end", {31'd0, redirect}, 0);
        check("beq_rpc_hold",  redirect_pc, 32'h120);
        check("bubble_valid",  {31'd0, out_valid}, 0);

        // BLTU not taken because cf=1. The data path must pass straight through.
        clr(); in_valid = 1; branch = 1; funct3 = 3'b110; cf = 1; alu_r = 32'hDEADBEEF;
        pc = 32'h200; imm = 32'h40; rs2_data = 32'hCAFE0001; rd = 5'd9; reg_write = 1;
        step();
        check("bltu_redirect", {31'd0, redirect}, 0);
        check("bltu_alu",      out_alu_r, 32'hDEADBEEF);
        check("bltu_link",     out_link, 32'h204);
        check("bltu_rs2",      out_rs2, 32'hCAFE0001);
        check("bltu_rd",       {27'd0, out_rd}, 9);
        check("bltu_f3",       {29'd0, out_funct3}, 6);
        check("bltu_rw",       {31'd0, out_reg_write}, 1);

        // Branch condition table. Each row lists funct3, cf, zf, vf, sf and the expected redirect.
        br(3'b100, 0, 0, 0, 1); step(); check("blt_taken",   {31'd0, redirect}, 1);
        br(3'b100, 0, 0, 1, 1); step(); check("blt_not",     {31'd0, redirect}, 0);
        br(3'b101, 0, 0, 1, 1); step(); check("bge_taken",   {31'd0, redirect}, 1);
        br(3'b111, 1, 0, 0, 0); step(); check("bgeu_taken",  {31'd0, redirect}, 1);
        br(3'b110, 0, 0, 0, 0); step(); check("bltu_taken",  {31'd0, redirect}, 1);
        br(3'b001, 0, 1, 0, 0); step(); check("bne_not",     {31'd0, redirect}, 0);
        br(3'b010, 1, 1, 1, 1); step(); check("f3_010_not",  {31'd0, redirect}, 0);
        br(3'b011, 0, 0, 0, 0); step(); check("f3_011_not",  {31'd0, redirect}, 0);

        // JALR to 0x1003: bit 0 is cleared giving 0x1002. Bit 1 is set, so misalign fires and the controls are dropped.
        clr(); in_valid = 1; jalr = 1; alu_r = 32'h0000_1003; reg_write = 1; mem_write = 1; pc = 32'h600;
        step();
        check("jalr_misalign", {31'd0, misalign}, 1);
        check("jalr_redirect", {31'd0, redirect}, 0);
        check("jalr_rpc",      redirect_pc, 32'h0000_1002);
        check("jalr_rw",       {31'd0, out_reg_write}, 0);
        check("jalr_mw",       {31'd0, out_mem_write}, 0);
        check("jalr_valid",    {31'd0, out_valid}, 1);
        clr();
        step();
        check("jalr_mis_end",  {31'd0, misalign}, 0);

        // in_valid=0: the controls must stay zero even when their inputs are high.
        clr(); reg_write = 1; mem_read = 1; mem_write = 1; alu_r = 32'h77; jal = 1;
        step();
        check("inv_rw",       {31'd0, out_reg_write}, 0);
        check("inv_mr",       {31'd0, out_mem_read}, 0);
        check("inv_mw",       {31'd0, out_mem_write}, 0);
        check("inv_redirect", {31'd0, redirect}, 0);
        check("inv_alu",      out_alu_r, 32'h77);

        // BNE taken and then stalled for 3 cycles. redirect must pulse once and out_* must stay stable.
        br(3'b001, 0, 0, 0, 0); pc = 32'h300; imm = 32'h40; alu_r = 32'h55; rd = 5'd7; rs2_data = 32'h66;
        step();
        check("bne_redirect", {31'd0, redirect}, 1);
        check("bne_rpc",      redirect_pc, 32'h340);
        check("bne_alu0",     out_alu_r, 32'h55);
        stall = 1;
        clr(); in_valid = 1; jal = 1; alu_r = 32'h99; rd = 5'd1; pc = 32'h800; reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_redirect", {31'd0, redirect}, 0);
            check("stall_alu",      out_alu_r, 32'h55);
            check("stall_rd",       {27'd0, out_rd}, 7);
            check("stall_link",     out_link, 32'h304);
            check("stall_rpc",      redirect_pc, 32'h340);
            check("stall_valid",    {31'd0, out_valid}, 1);
        end
        stall = 0;
        clr();
        step();

        // A store followed by flush and stall together. Flush wins, then capture resumes.
        clr(); in_valid = 1; mem_write = 1; alu_r = 32'h1000; rs2_data = 32'hABCD;
        step();
        check("st_mw", {31'd0, out_mem_write}, 1);
        flush = 1; stall = 1;
        step();
        check("fl_valid", {31'd0, out_valid}, 0);
        check("fl_mw",    {31'd0, out_mem_write}, 0);
        flush = 0; stall = 0;
        clr(); in_valid = 1; reg_write = 1; alu_r = 32'h77;
        step();
        check("resume_valid", {31'd0, out_valid}, 1);
        check("resume_alu",   out_alu_r, 32'h77);
        check("resume_rw",    {31'd0, out_reg_write}, 1);

        // A flush in the same cycle as a taken JAL suppresses its redirect.
        clr(); in_valid = 1; jal = 1; pc = 32'h700; imm = 32'h100; reg_write = 1;
        flush = 1;
        step();
        check("fl_jal_redirect", {31'd0, redirect}, 0);
        check("fl_jal_valid",    {31'd0, out_valid}, 0);
        check("fl_jal_rw",       {31'd0, out_reg_write}, 0);
        flush = 0;

        // Wrap-around case: 0xFFFFFFFC + 8 gives 0x4, and the link 0xFFFFFFFC + 4 gives 0x0.
        clr(); in_valid = 1; jal = 1; pc = 32'hFFFF_FFFC; imm = 32'd8; reg_write = 1;
        step();
        check("wrap_redirect", {31'd0, redirect}, 1);
        check("wrap_rpc",      redirect_pc, 32'h0000_0004);
        check("wrap_link",     out_link, 32'h0);

        // Reset during a stall of a taken jump. All outputs return to zero and no redirect is issued.
        clr(); in_valid = 1; jal = 1; pc = 32'h500; imm = 32'h10; alu_r = 32'h42;
        step();
        check("pre_rst_redirect", {31'd0, redirect}, 1);
        stall = 1; rst = 1;
        step();
        check("mid_rst_redirect", {31'd0, redirect}, 0);
        check("mid_rst_valid",    {31'd0, out_valid}, 0);
        check("mid_rst_rpc",      redirect_pc, 0);
        check("mid_rst_alu",      out_alu_r, 0);
        check("mid_rst_link",     out_link, 0);
        rst = 0; stall = 0;
        clr();
        step();
        check("post_rst_redirect", {31'd0, redirect}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
